// File: rtl/poly_eval_actor.sv
// poly_eval_actor: fifo-fed Horner evaluator popping x then a_N..a_0 and pushing one result.
module poly_eval_actor #(
  parameter int DATA_WIDTH = 8,
  parameter int DEGREE = 2,
  parameter int IDX_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_empty,
  output logic                  in_r_en,
  input  logic                  out_full,
  output logic                  out_w_en,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy,
  output logic                  done
);
  typedef enum logic [1:0] {IDLE, FETCH, CAPTURE, WRITE} state_t;
  localparam logic [IDX_WIDTH-1:0] LAST = IDX_WIDTH'(DEGREE + 1);
  state_t state;
  logic [DATA_WIDTH-1:0] x_reg, acc, next_acc;
  logic [IDX_WIDTH-1:0] idx;
  // Low DATA_WIDTH bits of the product are sign-agnostic, so plain wrapping arithmetic suffices.
  always_comb next_acc = idx == IDX_WIDTH'(1) ? in_data : acc * x_reg + in_data;
  assign in_r_en = state == FETCH && !in_empty;
  assign out_w_en = state == WRITE && !out_full;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      done <= 1'b0;
      out_data <= '0;
      x_reg <= '0;
      acc <= '0;
      idx <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= FETCH;
          idx <= '0;
        end
        FETCH: if (!in_empty) state <= CAPTURE;
        CAPTURE: begin
          if (idx == '0) x_reg <= in_data;
          else acc <= next_acc;
          idx <= idx + IDX_WIDTH'(1);
          if (idx == LAST) begin
            out_data <= next_acc;
            state <= WRITE;
          end else state <= FETCH;
        end
        WRITE: if (!out_full) begin
          state <= IDLE;
          done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_poly_eval_actor.sv
// tb_poly_eval_actor: directed firings checked against a power-sum polynomial model.
module tb_poly_eval_actor;
  logic clk = 0, reset = 1, start = 0, in_empty, in_r_en, out_full = 0, out_w_en, busy, done;
  logic [7:0] in_data = 0, out_data;
  logic stall_empty = 0;
  logic [7:0] tok [0:63];
  int rd = 0, wr = 0, errors = 0, checks = 0, wr_cnt = 0;
  logic [7:0] exp_q [$];

  poly_eval_actor dut (.clk(clk), .reset(reset), .start(start), .in_data(in_data),
    .in_empty(in_empty), .in_r_en(in_r_en), .out_full(out_full), .out_w_en(out_w_en),
    .out_data(out_data), .busy(busy), .done(done));

  always #5 clk = ~clk;
  always_comb in_empty = stall_empty || rd == wr;
  always @(posedge clk) if (in_r_en) begin
    in_data <= tok[rd % 64];
    rd <= rd + 1;
  end

  task automatic chk(input bit ok, input string nm, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  // Direct sum of a_i * x^i, reduced mod 256 at the end.
  function automatic logic [7:0] model(input int x, input int c2, input int c1, input int c0);
    longint s;
    s = longint'(c2) * x * x + longint'(c1) * x + c0;
    return s[7:0];
  endfunction

  task automatic push(input int v);
    tok[wr % 64] = 8'(v);
    wr++;
  endtask

  always @(negedge clk) begin
    #2;
    if (!reset) begin
      chk(!(in_r_en && out_w_en), "rd_wr_overlap", int'(in_r_en), 0);
      chk(!(in_r_en && in_empty), "rd_while_empty", int'(in_r_en), 0);
      if (out_w_en) begin
        wr_cnt++;
        if (exp_q.size() == 0) chk(0, "unexpected_write", int'(out_data), -1);
        else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          chk(out_data == e, "out_data", int'(out_data), int'(e));
        end
      end
    end
  end

  task automatic fire(input int x, input int c2, input int c1, input int c0, input logic [7:0] lit,
                      input int exp_wr, input int es_at, input int es_len, input int fs_at, input int fs_len);
    logic [7:0] m;
    int n, w0;
    bit got;
    m = model(x, c2, c1, c0);
    chk(m == lit, "model_pin", int'(m), int'(lit));
    push(x); push(c2); push(c1); push(c0);
    exp_q.push_back(m);
    @(negedge clk);
    start = 1;
    n = 0;
    got = 0;
    w0 = wr_cnt;
    while (n < 60 && !got) begin
      @(negedge clk);
      n++;
      start = (n == 4);
      stall_empty = n >= es_at && n < es_at + es_len;
      out_full = n >= fs_at && n < fs_at + fs_len;
      #1;
      if (out_full) begin
        chk(!out_w_en, "w_en_while_full", int'(out_w_en), 0);
        chk(out_data == m, "held_while_full", int'(out_data), int'(m));
      end
      got = out_w_en;
    end
    start = 0;
    chk(got && n == exp_wr, "write_cycle", n, exp_wr);
    @(negedge clk); #1;
    chk(done == 1, "done_pulse", int'(done), 1);
    chk(out_data == m, "out_data_hold", int'(out_data), int'(m));
    @(negedge clk); #3;
    chk(done == 0 && busy == 0, "idle_after", int'({done, busy}), 0);
    chk(wr_cnt - w0 == 1, "write_count", wr_cnt - w0, 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk({in_r_en, out_w_en, busy, done} == 0, "reset_ctrl", int'({in_r_en, out_w_en, busy, done}), 0);
    chk(out_data == 0, "reset_data", int'(out_data), 0);
    reset = 0;
    fire(2, 1, 2, 3, 8'd11, 9, 0, 0, 0, 0);
    fire(-1, 1, 2, 3, 8'd2, 9, 0, 0, 0, 0);
    fire(-3, 1, 0, -4, 8'd5, 9, 0, 0, 0, 0);
    fire(16, 1, 0, 0, 8'd0, 9, 0, 0, 0, 0);
    fire(16, 1, 0, 5, 8'd5, 9, 0, 0, 0, 0);
    fire(2, 1, 2, 3, 8'd11, 14, 5, 5, 0, 0);
    fire(2, 1, 2, 3, 8'd11, 13, 0, 0, 9, 4);
    // Abort a firing in the CAPTURE of token 2, then drop the unread remainder.
    push(7); push(1); push(2); push(3);
    @(negedge clk);
    start = 1;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      start = 0;
      reset = (n == 6);
    end
    @(negedge clk);
    reset = 0;
    #1;
    chk({in_r_en, out_w_en, busy, done} == 0, "midreset_ctrl", int'({in_r_en, out_w_en, busy, done}), 0);
    chk(out_data == 0, "midreset_data", int'(out_data), 0);
    wr = rd;
    fire(3, 2, -1, 4, 8'd19, 9, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk(exp_q.size() == 0, "pending_results", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
